// File: rtl/demux_1to5_32b_stream.sv
`default_nettype none
// ============================================================================
//  Module   : demux_1to5_32b_stream
//  Purpose  : Routes one input stream word to one of five buffered outputs,
//             chosen by a 3-bit select. Each output has a single-entry
//             register buffer, so a word appears one cycle after acceptance.
//             Words with select 5-7 are dropped, counted and flagged.
//  Ports    : clock, reset       - rising-edge clock, async active-high reset
//             in_data/in_valid/in_ready/select - input stream with its route
//             outN_data (N=0..4), out_valid[4:0], out_ready[4:0]
//                                - five registered output streams
//             drop_count         - saturating count of dropped words
//             err                - sticky flag, invalid select seen
//  Revision : 1.0 - initial release
// ============================================================================
module demux_1to5_32b_stream #(
  parameter int size = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [size-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      select,
  output logic [size-1:0] out0_data,
  output logic [size-1:0] out1_data,
  output logic [size-1:0] out2_data,
  output logic [size-1:0] out3_data,
  output logic [size-1:0] out4_data,
  output logic [4:0]      out_valid,
  input  logic [4:0]      out_ready,
  output logic [15:0]     drop_count,
  output logic            err
);

  localparam logic [15:0] c_drop_max = 16'hFFFF;

  logic [size-1:0] data_q [5];
  logic [4:0]      full_q;
  logic [4:0]      push;
  logic            sel_ok;
  logic            drop;

  assign sel_ok = (select <= 3'd4);

  // Ready looks only at the addressed buffer: it can take a word if empty or
  // if that buffer is draining on this same edge. Invalid routes always
  // accept so the stream can never stall on a bad select.
  always_comb begin
    in_ready = 1'b1;
    case (select)
      3'd0:    in_ready = !full_q[0] || out_ready[0];
      3'd1:    in_ready = !full_q[1] || out_ready[1];
      3'd2:    in_ready = !full_q[2] || out_ready[2];
      3'd3:    in_ready = !full_q[3] || out_ready[3];
      3'd4:    in_ready = !full_q[4] || out_ready[4];
      default: in_ready = 1'b1;
    endcase
  end

  assign drop = in_valid && !sel_ok;

  genvar j;
  generate
    for (j = 0; j < 5; j = j + 1) begin : g_buf
      assign push[j] = in_valid && in_ready && (select == 3'(j));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          full_q[j] <= 1'b0;
          data_q[j] <= '0;
        end else begin
          // A push wins over a pop, so pop+push on one edge keeps the
          // buffer full with the new word (full throughput).
          if (push[j]) begin
            full_q[j] <= 1'b1;
            data_q[j] <= in_data;
          end else if (full_q[j] && out_ready[j]) begin
            full_q[j] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= 16'd0;
      err        <= 1'b0;
    end else if (drop) begin
      err <= 1'b1;
      if (drop_count != c_drop_max) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign out_valid = full_q;
  assign out0_data = data_q[0];
  assign out1_data = data_q[1];
  assign out2_data = data_q[2];
  assign out3_data = data_q[3];
  assign out4_data = data_q[4];

endmodule
`default_nettype wire

// File: tb/tb_demux_1to5_32b_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_1to5_32b_stream
//  Purpose  : Scoreboard bench for demux_1to5_32b_stream. Stimulus pushes
//             accepted words into per-output expected queues; a monitor on
//             the falling edge compares presented outputs and pops them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_demux_1to5_32b_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  select = '0;
  logic [31:0] out0_data, out1_data, out2_data, out3_data, out4_data;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready = '0;
  logic [15:0] drop_count;
  logic        err;

  demux_1to5_32b_stream #(.size(32)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .select(select),
    .out0_data(out0_data), .out1_data(out1_data), .out2_data(out2_data),
    .out3_data(out3_data), .out4_data(out4_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .drop_count(drop_count), .err(err)
  );

  always #5 clock = ~clock;

  logic [31:0] od [5];
  assign od[0] = out0_data;
  assign od[1] = out1_data;
  assign od[2] = out2_data;
  assign od[3] = out3_data;
  assign od[4] = out4_data;

  // Reference model: words accepted for each output and not yet consumed,
  // the value each output register should show, and the drop bookkeeping.
  logic [31:0] exp_q [5][$];
  logic [31:0] last_data [5];
  int unsigned m_drops = 0;
  bit          m_err = 0;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      exp_q[k].delete();
      last_data[k] = '0;
    end
    m_drops = 0;
    m_err = 0;
  endtask

  // Monitor: sample mid-cycle, consume words a ready consumer takes.
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(exp_q[k].size() != 0));
        chk($sformatf("out%0d_data", k), 64'(od[k]), 64'(last_data[k]));
        if (exp_q[k].size() != 0 && out_ready[k]) begin
          logic [31:0] w;
          w = exp_q[k].pop_front();
          chk($sformatf("pop%0d_word", k), 64'(od[k]), 64'(w));
        end
      end
      chk("drop_count", 64'(drop_count), 64'(m_drops));
      chk("err", 64'(err), 64'(m_err));
    end
  end

  // One clock of stimulus; inputs change just after the rising edge, the
  // ready check and model update happen after the monitor's mid-cycle pass.
  task automatic cycle(input bit v, input logic [2:0] s, input logic [31:0] d,
                       input logic [4:0] r);
    bit rdy;
    @(posedge clock);
    #1;
    in_valid = v; select = s; in_data = d; out_ready = r;
    @(negedge clock);
    #2;
    rdy = (s > 3'd4) ? 1'b1 : (exp_q[s].size() == 0);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    if (v && rdy) begin
      if (s > 3'd4) begin
        m_err = 1;
        if (m_drops < 32'hFFFF) m_drops++;
      end else begin
        exp_q[s].push_back(d);
        last_data[s] = d;
      end
    end
  endtask

  initial begin
    model_clear();
    // Fresh reset
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_drop_count", 64'(drop_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Single word to output 2, nobody consuming
    cycle(1, 3'd2, 32'hA5A5_0001, 5'b00000);
    cycle(0, 3'd0, 32'h0, 5'b00000);
    chk("single_valid", 64'(out_valid), 64'b00100);
    chk("single_data", 64'(out2_data), 64'hA5A5_0001);
    cycle(0, 3'd0, 32'h0, 5'b00000);

    // Back-pressure on output 2, then release: replace on same edge
    cycle(1, 3'd2, 32'hBEEF_0002, 5'b00000);
    cycle(1, 3'd2, 32'hBEEF_0002, 5'b00000);
    cycle(1, 3'd2, 32'hBEEF_0003, 5'b00100);
    cycle(0, 3'd2, 32'h0, 5'b00000);
    chk("replace_data", 64'(out2_data), 64'hBEEF_0003);
    cycle(0, 3'd2, 32'h0, 5'b00100);

    // Streaming 1..8 into output 4 at full rate
    for (int i = 1; i <= 8; i++) cycle(1, 3'd4, 32'(i), 5'b10000);
    cycle(0, 3'd4, 32'h0, 5'b10000);
    cycle(0, 3'd4, 32'h0, 5'b10000);
    chk("stream_last", 64'(out4_data), 64'd8);

    // Invalid select, three drops
    for (int i = 0; i < 3; i++) cycle(1, 3'd6, 32'hDEAD_0000 + 32'(i), 5'b00000);
    cycle(0, 3'd0, 32'h0, 5'b00000);
    chk("drop3_count", 64'(drop_count), 64'd3);
    chk("drop3_err", 64'(err), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] s;
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      cycle(bit'($urandom_range(0, 3) != 0), s, $urandom, 5'($urandom));
    end

    // Saturate drop_count, then one more
    for (int i = 0; i < 65535; i++) cycle(1, 3'($urandom_range(5, 7)), $urandom, 5'b11111);
    cycle(1, 3'd7, 32'h1, 5'b11111);
    cycle(0, 3'd0, 32'h0, 5'b11111);
    chk("sat_count", 64'(drop_count), 64'hFFFF);

    // Fill outputs 0 and 3, then async reset between edges
    cycle(1, 3'd0, 32'h1111_0000, 5'b00000);
    cycle(1, 3'd3, 32'h3333_0000, 5'b00000);
    cycle(0, 3'd0, 32'h0, 5'b00000);
    chk("prereset_valid", 64'(out_valid), 64'b01001);
    #1 reset = 1'b1;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_drop_count", 64'(drop_count), 64'd0);
    chk("async_err", 64'(err), 64'd0);
    chk("async_out0", 64'(out0_data), 64'd0);
    chk("async_out3", 64'(out3_data), 64'd0);
    model_clear();
    in_valid = 1'b1; select = 3'd1; in_data = 32'h7777_7777;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_hold_valid", 64'(out_valid), 64'd0);
    reset = 1'b0; in_valid = 1'b0;
    cycle(1, 3'd0, 32'hC0DE_0000, 5'b00000);
    cycle(0, 3'd0, 32'h0, 5'b00000);
    chk("post_reset_valid", 64'(out_valid), 64'b00001);
    chk("post_reset_data", 64'(out0_data), 64'hC0DE_0000);
    cycle(0, 3'd0, 32'h0, 5'b11111);
    cycle(0, 3'd0, 32'h0, 5'b11111);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
